serial_add_nb: RTL and testbench

- Multi-cycle N-bit add/subtract unit built around one 4-bit carry-lookahead slice (existing module carryLA_4b; ports A, B, CI, SUM, CO, Ofl), reused once per nibble, LSB nibble first.
- Sits in the execute stage as the area-reduced adder option.
- Drives the slice's A/B/CI and consumes its SUM/CO/Ofl.
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/serial_add_nb_pkg.sv | 12 +
 rtl/carryLA_4b.sv | 31 +++
 rtl/serial_add_nb.sv | 128 ++++++++++++
 tb/tb_serial_add_nb.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_nb_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and slice width.
package serial_add_nb_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/carryLA_4b.sv
// 4-bit carry-lookahead adder slice with carry-out and signed-overflow flag.
module carryLA_4b (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       CI,
   output logic [3:0] SUM,
   output logic       CO,
   output logic       Ofl
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = A & B;
   assign p = A ^ B;

   assign c[0] = CI;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

   assign SUM = p ^ c[3:0];
   assign CO  = c[4];
   // Signed overflow: carry into the MSB differs from carry out of it.
   assign Ofl = c[4] ^ c[3];

endmodule

// File: rtl/serial_add_nb.sv
// Multi-cycle WIDTH-bit add/subtract reusing one 4-bit CLA slice per nibble, LSB first,
// with valid/ready handshakes on operands and result.
module serial_add_nb
   import serial_add_nb_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ofl,
   output logic             zero
);

   localparam int NIB   = WIDTH / NIBBLE_W;
   localparam int CNT_W = $clog2(NIB);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

   state_e           state_q;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic             carry_q;
   logic [WIDTH-1:0] sum_q;
   logic             co_q;
   logic             ofl_q;
   logic             zero_q;
   logic             out_valid_q;
   logic             in_ready_q;

   logic [NIBBLE_W-1:0] slice_a;
   logic [NIBBLE_W-1:0] slice_b;
   logic [NIBBLE_W-1:0] slice_sum;
   logic                slice_co;
   logic                slice_ofl;

   // NOTE: every variable gets a default first so always_comb never infers a latch.
   always_comb begin
      slice_a = a_q[NIBBLE_W*count_q +: NIBBLE_W];
      slice_b = b_q[NIBBLE_W*count_q +: NIBBLE_W];
      acc_d   = acc_q;
      acc_d[NIBBLE_W*count_q +: NIBBLE_W] = slice_sum;
   end

   carryLA_4b u_slice (
      .A   (slice_a),
      .B   (slice_b),
      .CI  (carry_q),
      .SUM (slice_sum),
      .CO  (slice_co),
      .Ofl (slice_ofl)
   );

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         carry_q     <= 1'b0;
         sum_q       <= '0;
         co_q        <= 1'b0;
         ofl_q       <= 1'b0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= sub ? ~b : b;
                  carry_q    <= sub ? 1'b1 : ci;
                  count_q    <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               acc_q   <= acc_d;
               carry_q <= slice_co;
               if (count_q == LAST) begin
                  co_q    <= slice_co;
                  ofl_q   <= slice_ofl;
                  count_q <= '0;
                  state_q <= DONE;
               end else begin
                  count_q <= count_q + 1'b1;
               end
            end
            DONE: begin
               // First DONE cycle publishes the completed sum; later cycles wait for the consumer.
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
                  sum_q       <= acc_q;
                  zero_q      <= (acc_q == '0);
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign co        = co_q;
   assign ofl       = ofl_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_serial_add_nb.sv
// Self-checking bench for serial_add_nb: directed corner cases plus randomized ops
// against an arithmetic reference model.
module tb_serial_add_nb;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             ci = 1'b0;
   logic             sub = 1'b0;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] sum;
   logic             co;
   logic             ofl;
   logic             zero;

   int     n_checks = 0;
   int     n_errors = 0;
   longint cyc = 0;
   longint last_accept = -1;

   serial_add_nb #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .co        (co),
      .ofl       (ofl),
      .zero      (zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands, signed range test for overflow.
   task automatic model(input logic [WIDTH-1:0] av, bv, input logic civ, subv,
                        output logic [WIDTH-1:0] s, output logic c, output logic o);
      int full;
      int sres;
      int sa;
      int sb;
      sa = int'($signed(av));
      sb = int'($signed(bv));
      if (subv) begin
         s    = av - bv;
         c    = (av >= bv);
         sres = sa - sb;
      end else begin
         full = int'(av) + int'(bv) + int'(civ);
         s    = full[WIDTH-1:0];
         c    = (full > 65535);
         sres = sa + sb + int'(civ);
      end
      o = (sres > 32767) || (sres < -32768);
   endtask

   task automatic start_op(input logic [WIDTH-1:0] av, bv, input logic civ, subv);
      int guard = 0;
      while (!in_ready && guard < 20) begin
         @(posedge clk);
         @(negedge clk);
         guard++;
      end
      check("in_ready_wait", 32'(in_ready), 32'd1);
      a = av; b = bv; ci = civ; sub = subv; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (last_accept >= 0)
         check("issue_interval", 32'((cyc - last_accept) >= longint'(NIB + 2)), 32'd1);
      last_accept = cyc;
      in_valid = 1'b0;
      a = WIDTH'($urandom); b = WIDTH'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      check("in_ready_busy", 32'(in_ready), 32'd0);
   endtask

   task automatic wait_result();
      int lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'(NIB + 1));
   endtask

   task automatic check_result(input logic [WIDTH-1:0] av, bv, input logic civ, subv);
      logic [WIDTH-1:0] es;
      logic ec;
      logic eo;
      model(av, bv, civ, subv, es, ec, eo);
      check("sum", 32'(sum), 32'(es));
      check("co", 32'(co), 32'(ec));
      check("ofl", 32'(ofl), 32'(eo));
      check("zero", 32'(zero), 32'(es == '0));
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("drain_out_valid", 32'(out_valid), 32'd0);
      check("drain_in_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic directed(input logic [WIDTH-1:0] av, bv, input logic civ, subv,
                           input logic [WIDTH-1:0] es, input logic ec, eo, ez);
      start_op(av, bv, civ, subv);
      wait_result();
      check_result(av, bv, civ, subv);
      check("dir_sum", 32'(sum), 32'(es));
      check("dir_co", 32'(co), 32'(ec));
      check("dir_ofl", 32'(ofl), 32'(eo));
      check("dir_zero", 32'(zero), 32'(ez));
      drain();
   endtask

   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rci;
      logic             rsub;
      bit               saw_valid;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_co", 32'(co), 32'd0);
      check("rst_ofl", 32'(ofl), 32'd0);
      check("rst_zero", 32'(zero), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      directed(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      directed(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

      // Backpressure: result must hold while the consumer stalls and new operands are ignored.
      start_op(16'h1234, 16'h1111, 1'b1, 1'b0);
      wait_result();
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         a = WIDTH'($urandom); b = WIDTH'($urandom); ci = 1'($urandom); sub = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         check("stall_sum", 32'(sum), 32'h2346);
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      drain();
      check("post_drain_sum", 32'(sum), 32'h2346);

      // Reset mid-RUN aborts without ever presenting a partial result.
      start_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_sum", 32'(sum), 32'd0);
      check("abort_co", 32'(co), 32'd0);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      last_accept = -1;
      saw_valid = 1'b0;
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      check("abort_no_result", 32'(saw_valid), 32'd0);
      directed(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

      // Randomized back-to-back ops with the consumer always ready.
      out_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         ra   = WIDTH'($urandom);
         rb   = WIDTH'($urandom);
         rci  = 1'($urandom);
         rsub = 1'($urandom);
         if (i % 50 == 0) rb = ra;
         start_op(ra, rb, rci, rsub);
         wait_result();
         check_result(ra, rb, rci, rsub);
      end
      out_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
